mult_sched: RTL
===============

Name: mult_sched

Overview:
Two-requester scheduler and sequencer for the shared shift-add multiplier datapath.
- Arbitrates round-robin between two clients and steers operand selection to the datapath.
- Generates the per-cycle load/add/shift strobes from an internal bit counter, so the datapath's K input is produced internally rather than supplied externally.
- Returns a one-cycle done pulse to the client that owns the job.
- Sits between the client blocks and the multiplier register/adder datapath.

Parameters:
N_BITS, 4, multiplier operand width; number of add/shift iterations per job (N_BITS >= 2)
CNT_W, 3, bit-counter width; must satisfy 2^CNT_W > N_BITS

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
req  in  2  job request per client; held high until that client's done pulse
m  in  1  current multiplier LSB from datapath
sel  out  1  operand mux select to datapath (index of owning client)
load  out  1  datapath load strobe
sh  out  1  datapath shift strobe
ad  out  1  datapath add strobe
grant  out  2  one-hot owner of the datapath; 0 when idle
done  out  2  one-cycle completion pulse to the owning client
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (sync, rst=1 at edge):
  - state=IDLE, counter=0, last=1.
  - grant=0, done=0, sel=0, load=sh=ad=0, busy=0.
  - Reset wins over all other events, including mid-job; the job is discarded with no done pulse.
- States: IDLE, LOAD, ADD, SHIFT, DONE. All strobe outputs are decoded from registered state; m is sampled combinationally in ADD only.
- IDLE:
  - If any req bit is high at the edge, go to LOAD.
  - Latch the owner into grant/sel and set last=owner.
  - If no req bit is high, stay in IDLE.
- Arbitration:
  - Single request: that client wins.
  - Both requests: the client != last wins.
  - Because last resets to 1, client 0 wins the first tie.
- LOAD: load=1 for one cycle; clear counter; go to ADD.
- ADD: ad=m; go to SHIFT.
- SHIFT:
  - sh=1; counter increments.
  - If counter==N_BITS-1 before the increment (internal K), go to DONE; else go to ADD.
- DONE:
  - done[owner]=1 for exactly one cycle; grant stays valid this cycle.
  - Next state is IDLE; grant clears on entry to IDLE.
- Latency: req sampled at edge E0 → LOAD in cycle after E0 → done high in the cycle after edge E0+2*N_BITS+1. N_BITS=4 gives 10 cycles, req edge to done inclusive.
- Exactly 2*N_BITS+2 busy cycles per job. At least one IDLE cycle separates consecutive jobs.
- Client contract: a client deasserts req in the cycle after its done pulse.
  - The req of the just-finished client is ignored in the IDLE cycle that directly follows DONE.
  - If both clients are requesting then, the other client wins.
- req deasserted mid-job: ignored. The job runs to completion and done still pulses.
- req of the non-owner during a job: ignored until IDLE; no queueing beyond the held level.
- grant and sel are stable for the whole job. sel holds its last value while idle.
- Exactly one of load/sh/ad can be high in any cycle.
- ad is never asserted outside ADD, even if m=1.

Optional Feature:
Macro MULT_SCHED_STATS_EN.
- Defined:
  - Adds outputs jobs0 and jobs1 (16 bits each): completed-job counters per client.
  - Each counter increments in the DONE cycle of its client and saturates at 16'hFFFF.
  - Both clear on rst.
  - Adds output ovf (1 bit), sticky: set when either counter saturates, cleared only by rst.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- rst high 2 cycles with req=2'b11 → grant=0, busy=0, all strobes 0; first edge after rst low enters LOAD with grant=2'b01.
- Single job, N_BITS=4: req=2'b10, m pattern 1,0,1,1 across ADD cycles:
  - sel=1; load 1 cycle; ad high in ADD cycles 1, 3, 4; sh high 4 times.
  - done=2'b10 exactly 10 cycles after the req sample edge.
- Contention: req=2'b11 held continuously → grants alternate 01, 10, 01, each job 10 busy cycles, one IDLE cycle between jobs; done never overlaps the other client.
- Mid-job drop: client 0 deasserts req during the second ADD → job completes; done[0] still pulses at the nominal cycle.
- Reset mid-job: assert rst in the third SHIFT → next cycle IDLE, no done pulse; counter restarts from 0 on the next job.
- With MULT_SCHED_STATS_EN, preload jobs0=16'hFFFE via force and run 2 jobs on client 0 → jobs0=16'hFFFF, ovf=1; jobs1 unchanged.

Source files
------------

// File: rtl/mult_sched.sv
// Round-robin two-client scheduler and strobe sequencer for a shared shift-add multiplier.
// Optional per-client completed-job counters are enabled by defining MULT_SCHED_STATS_EN.
module mult_sched #(
    parameter int N_BITS = 4,
    parameter int CNT_W  = 3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       m_i,
    output logic       sel_o,
    output logic       load_o,
    output logic       sh_o,
    output logic       ad_o,
    output logic [1:0] grant_o,
    output logic [1:0] done_o,
    output logic       busy_o
`ifdef MULT_SCHED_STATS_EN
    ,
    output logic [15:0] jobs0_o,
    output logic [15:0] jobs1_o,
    output logic        ovf_o
`endif
);

    typedef enum logic [2:0] {IDLE, LOAD, ADD, SHIFT, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_BITS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             last_q;
    logic             post_done_q;
    logic [1:0]       grant_q;
    logic [1:0]       done_q;
    logic             sel_q;
    logic             load_q;
    logic             sh_q;
    logic             add_q;
    logic             busy_q;
    logic [1:0]       req_eff;
    logic             owner_d;

    // The client that just finished still holds req for one cycle after done; mask it.
    always_comb begin
        req_eff = req_i;
        if (post_done_q) begin
            req_eff = req_i & (last_q ? 2'b01 : 2'b10);
        end
        unique case (req_eff)
            2'b01:   owner_d = 1'b0;
            2'b10:   owner_d = 1'b1;
            2'b11:   owner_d = ~last_q;
            default: owner_d = last_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = (req_eff != 2'b00) ? LOAD : IDLE;
            LOAD:    state_d = ADD;
            ADD:     state_d = SHIFT;
            SHIFT:   state_d = (cnt_q == CNT_LAST) ? DONE : ADD;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_q      <= 1'b1;
            post_done_q <= 1'b0;
            grant_q     <= 2'b00;
            done_q      <= 2'b00;
            sel_q       <= 1'b0;
            load_q      <= 1'b0;
            sh_q        <= 1'b0;
            add_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            post_done_q <= (state_q == DONE);
            load_q      <= (state_d == LOAD);
            add_q       <= (state_d == ADD);
            sh_q        <= (state_d == SHIFT);
            busy_q      <= (state_d != IDLE);
            done_q      <= (state_d == DONE) ? grant_q : 2'b00;
            unique case (state_q)
                IDLE: begin
                    if (state_d == LOAD) begin
                        grant_q <= owner_d ? 2'b10 : 2'b01;
                        sel_q   <= owner_d;
                        last_q  <= owner_d;
                    end
                end
                LOAD:    cnt_q   <= '0;
                SHIFT:   cnt_q   <= cnt_q + 1'b1;
                DONE:    grant_q <= 2'b00;
                default: ;
            endcase
        end
    end

    assign sel_o   = sel_q;
    assign load_o  = load_q;
    assign sh_o    = sh_q;
    assign ad_o    = add_q & m_i;
    assign grant_o = grant_q;
    assign done_o  = done_q;
    assign busy_o  = busy_q;

`ifdef MULT_SCHED_STATS_EN
    logic [15:0] jobs0_q;
    logic [15:0] jobs1_q;
    logic        ovf_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            jobs0_q <= 16'h0000;
            jobs1_q <= 16'h0000;
            ovf_q   <= 1'b0;
        end else if (state_q == DONE) begin
            if (grant_q[0] && jobs0_q != 16'hFFFF) begin
                jobs0_q <= jobs0_q + 16'd1;
                if (jobs0_q == 16'hFFFE) ovf_q <= 1'b1;
            end
            if (grant_q[1] && jobs1_q != 16'hFFFF) begin
                jobs1_q <= jobs1_q + 16'd1;
                if (jobs1_q == 16'hFFFE) ovf_q <= 1'b1;
            end
        end
    end

    assign jobs0_o = jobs0_q;
    assign jobs1_o = jobs1_q;
    assign ovf_o   = ovf_q;
`endif

endmodule
